// File: rtl/if_bp_stage.sv
// Instruction-fetch stage with a direct-mapped BTB and 2-bit bimodal predictor.
// Drives a synchronous instruction RAM one cycle ahead of the fetched pc.
module if_bp_stage #(
  parameter logic [31:0] PC_RESET    = 32'h1c000000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        ipd_allow_in,
  output logic        inst_ram_en,
  output logic [31:0] inst_ram_addr,
  output logic [3:0]  inst_ram_w_en,
  output logic [31:0] inst_ram_w_data,
  output logic        if_to_ipd_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pred_pc,
  output logic        if_pred_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [31:0] pc;
  logic        if_valid;

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [31:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic             pred_taken;
  logic [31:0]      pred_pc;
  logic [31:0]      next_pc;
  logic             allow_in;
  logic             ready_go;
  logic             fetch_fire;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_ok;

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign rd_idx     = pc[IDX_W+1:2];
  assign rd_tag     = pc[31:IDX_W+2];
  assign rd_hit     = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);
  assign pred_taken = rd_hit && btb_ctr[rd_idx][1];
  assign pred_pc    = pred_taken ? btb_target[rd_idx] : pc + 32'd4;

  assign next_pc    = redirect_valid ? redirect_pc : pred_pc;
  assign ready_go   = 1'b1;
  assign allow_in   = ~if_valid | (ready_go & ipd_allow_in);
  assign fetch_fire = allow_in | redirect_valid;

  // When stalled the RAM enable drops so its output keeps the current word.
  assign inst_ram_en     = ~reset & fetch_fire;
  assign inst_ram_addr   = next_pc;
  assign inst_ram_w_en   = 4'b0000;
  assign inst_ram_w_data = 32'h0000_0000;

  assign if_to_ipd_valid = if_valid;
  assign if_pc           = pc;
  assign if_pred_pc      = pred_pc;
  assign if_pred_taken   = pred_taken;

  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[31:IDX_W+2];
  assign upd_hit   = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  assign unused_ok = &{1'b0, upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_RESET - 32'd4;
      if_valid <= 1'b0;
    end else if (fetch_fire) begin
      pc       <= next_pc;
      if_valid <= 1'b1;
    end
  end

  // Training: hits move the counter, taken misses allocate at weakly-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_ctr[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (btb_ctr[upd_idx] != 2'b11) begin
            btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
          end
          btb_target[upd_idx] <= upd_target;
        end else if (btb_ctr[upd_idx] != 2'b00) begin
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target;
        btb_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if_bp_stage.sv
// Directed vector table plus randomized run against a behavioural predictor model.
module tb_if_bp_stage;

  localparam logic [31:0] PC_RESET = 32'h1c000000;
  localparam int          N        = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        ipd_allow_in;
  logic        inst_ram_en;
  logic [31:0] inst_ram_addr;
  logic [3:0]  inst_ram_w_en;
  logic [31:0] inst_ram_w_data;
  logic        if_to_ipd_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pred_pc;
  logic        if_pred_taken;

  if_bp_stage #(.PC_RESET(PC_RESET), .BTB_ENTRIES(N)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .ipd_allow_in(ipd_allow_in),
    .inst_ram_en(inst_ram_en), .inst_ram_addr(inst_ram_addr),
    .inst_ram_w_en(inst_ram_w_en), .inst_ram_w_data(inst_ram_w_data),
    .if_to_ipd_valid(if_to_ipd_valid), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc), .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        allow;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_pred;
    logic        e_t;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Behavioural predictor: one record per table slot, counters as plain integers.
  logic [31:0] m_pc;
  bit          m_ifv;
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];

  function automatic vec_t mk(logic rst, logic rv, logic [31:0] rpc, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic allow, logic e_en,
                              logic [31:0] e_addr, logic e_v, logic [31:0] e_pc,
                              logic [31:0] e_pred, logic e_t);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.allow = allow; v.e_en = e_en; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc;
    v.e_pred = e_pred; v.e_t = e_t;
    return v;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit taken,
                                       output logic [31:0] npc);
    int idx;
    idx   = int'((pc / 4) % N);
    taken = m_v[idx] && (m_tag[idx] == pc / (4 * N)) && (m_ctr[idx] >= 2);
    npc   = taken ? m_tgt[idx] : pc + 32'd4;
  endfunction

  function automatic vec_t model_expect(input vec_t v);
    vec_t        e;
    bit          t;
    logic [31:0] p;
    e = v;
    model_lookup(m_pc, t, p);
    e.e_en   = !v.rst && (!m_ifv || v.allow || v.rv);
    e.e_addr = v.rv ? v.rpc : p;
    e.e_v    = m_ifv;
    e.e_pc   = m_pc;
    e.e_pred = p;
    e.e_t    = t;
    return e;
  endfunction

  task automatic model_step(input vec_t v);
    bit          t;
    logic [31:0] p;
    int          idx;
    if (v.rst) begin
      m_pc  = PC_RESET - 32'd4;
      m_ifv = 0;
      for (int i = 0; i < N; i++) begin
        m_v[i]   = 0;
        m_ctr[i] = 1;
      end
      return;
    end
    model_lookup(m_pc, t, p);
    if (!m_ifv || v.allow || v.rv) begin
      m_pc  = v.rv ? v.rpc : p;
      m_ifv = 1;
    end
    if (v.uv) begin
      idx = int'((v.upc / 4) % N);
      if (m_v[idx] && m_tag[idx] == v.upc / (4 * N)) begin
        if (v.ut) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = v.utgt;
        end else begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
      end else if (v.ut) begin
        m_v[idx]   = 1;
        m_tag[idx] = v.upc / (4 * N);
        m_tgt[idx] = v.utgt;
        m_ctr[idx] = 2;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset          = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    upd_valid      = v.uv;
    upd_pc         = v.upc;
    upd_taken      = v.ut;
    upd_target     = v.utgt;
    ipd_allow_in   = v.allow;
  endtask

  task automatic check_one(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input vec_t e);
    check_one({tag, " inst_ram_en"},     32'(inst_ram_en),     32'(e.e_en));
    check_one({tag, " inst_ram_addr"},   inst_ram_addr,        e.e_addr);
    check_one({tag, " if_to_ipd_valid"}, 32'(if_to_ipd_valid), 32'(e.e_v));
    check_one({tag, " if_pc"},           if_pc,                e.e_pc);
    check_one({tag, " if_pred_pc"},      if_pred_pc,           e.e_pred);
    check_one({tag, " if_pred_taken"},   32'(if_pred_taken),   32'(e.e_t));
    check_one({tag, " inst_ram_w_en"},   32'(inst_ram_w_en),   32'h0);
    check_one({tag, " inst_ram_w_data"}, inst_ram_w_data,      32'h0);
  endtask

  task automatic advance(input vec_t v);
    @(posedge clk);
    model_step(v);
  endtask

  initial begin
    vec_t v;
    vec_t e;

    // Reset-state row first, then sequential fetch, stall, training, redirect, alias, reset.
    vecs.push_back(mk(1,0,0,0,0,0,0,1, 0,32'h1c000000,0,32'h1bfffffc,32'h1c000000,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000000,0,32'h1bfffffc,32'h1c000000,0));
    vecs.push_back(mk(0,0,0,1,32'h1c000010,1,32'h1c000100,1, 1,32'h1c000004,1,32'h1c000000,32'h1c000004,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000008,1,32'h1c000004,32'h1c000008,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,32'h1c00000c,1,32'h1c000008,32'h1c00000c,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,32'h1c00000c,1,32'h1c000008,32'h1c00000c,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0, 0,32'h1c00000c,1,32'h1c000008,32'h1c00000c,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c00000c,1,32'h1c000008,32'h1c00000c,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000010,1,32'h1c00000c,32'h1c000010,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000100,1,32'h1c000010,32'h1c000100,1));
    vecs.push_back(mk(0,0,0,1,32'h1c000010,0,0,1, 1,32'h1c000104,1,32'h1c000100,32'h1c000104,0));
    vecs.push_back(mk(0,1,32'h1c000010,1,32'h1c000010,0,0,1, 1,32'h1c000010,1,32'h1c000104,32'h1c000108,0));
    vecs.push_back(mk(0,0,0,1,32'h1c000010,0,0,1, 1,32'h1c000014,1,32'h1c000010,32'h1c000014,0));
    vecs.push_back(mk(0,0,0,1,32'h1c000010,1,32'h1c000100,1, 1,32'h1c000018,1,32'h1c000014,32'h1c000018,0));
    vecs.push_back(mk(0,0,0,1,32'h1c000010,1,32'h1c000100,1, 1,32'h1c00001c,1,32'h1c000018,32'h1c00001c,0));
    vecs.push_back(mk(0,1,32'h1c000010,0,0,0,0,1, 1,32'h1c000010,1,32'h1c00001c,32'h1c000020,0));
    vecs.push_back(mk(0,1,32'h1c000200,0,0,0,0,1, 1,32'h1c000200,1,32'h1c000010,32'h1c000100,1));
    vecs.push_back(mk(0,1,32'h1c000200,0,0,0,0,0, 1,32'h1c000200,1,32'h1c000200,32'h1c000204,0));
    vecs.push_back(mk(0,1,32'h1c000050,0,0,0,0,0, 1,32'h1c000050,1,32'h1c000200,32'h1c000204,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000054,1,32'h1c000050,32'h1c000054,0));
    vecs.push_back(mk(1,1,32'h1c000300,1,32'h1c000050,1,32'h1c000400,1, 0,32'h1c000300,1,32'h1c000054,32'h1c000058,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000000,0,32'h1bfffffc,32'h1c000000,0));
    vecs.push_back(mk(0,1,32'h1c000010,0,0,0,0,1, 1,32'h1c000010,1,32'h1c000000,32'h1c000004,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,1, 1,32'h1c000014,1,32'h1c000010,32'h1c000014,0));

    v = vecs[0];
    repeat (2) begin
      applyStimulus(v);
      advance(v);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      advance(vecs[i]);
    end

    v = vecs[0];
    applyStimulus(v);
    advance(v);

    for (int c = 0; c < 3000; c++) begin
      v.rst   = ($urandom_range(0, 99) == 0);
      v.rv    = ($urandom_range(0, 7) == 0);
      v.rpc   = ($urandom_range(0, 19) == 0) ? 32'hfffffffc
                                             : PC_RESET + 32'(4 * $urandom_range(0, 31));
      v.uv    = ($urandom_range(0, 2) == 0);
      v.upc   = PC_RESET + 32'(4 * $urandom_range(0, 31));
      v.ut    = ($urandom_range(0, 2) != 0);
      v.utgt  = PC_RESET + 32'(4 * $urandom_range(0, 31));
      v.allow = ($urandom_range(0, 3) != 0);
      applyStimulus(v);
      #1;
      e = model_expect(v);
      checkOutput($sformatf("rand%0d", c), e);
      advance(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_bp_stage.md
IF_BP_STAGE -- requirements
Module: if_bp_stage

Interface
REQ-001 SHALL expose parameter PC_RESET, default 32'h1c000000, meaning the first fetch address after reset.
REQ-002 SHALL expose parameter BTB_ENTRIES, default 16, meaning the number of BTB/BHT entries (power of two, 4..256); IDX_W = log2(BTB_ENTRIES).
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port redirect_valid, input, 1: the downstream stage has detected a mispredict this cycle.
REQ-006 SHALL have port redirect_pc, input, 32: the correct fetch address when redirect_valid=1.
REQ-007 SHALL have port upd_valid, input, 1: a resolved branch predictor update this cycle.
REQ-008 SHALL have ports upd_pc (32), upd_taken (1) and upd_target (32), all inputs: the resolved branch address, its outcome and its target.
REQ-009 SHALL have port ipd_allow_in, input, 1: the downstream stage accepts data this cycle.
REQ-010 SHALL have ports inst_ram_en (output, 1), inst_ram_addr (output, 32), inst_ram_w_en (output, 4) and inst_ram_w_data (output, 32).
REQ-011 SHALL have ports if_to_ipd_valid (1), if_pc (32), if_pred_pc (32) and if_pred_taken (1), all outputs: the fetched instruction's valid flag, its PC, its predicted next PC and its taken-prediction flag.

Function
REQ-012 SHALL hold a pc register plus, per entry: valid bit, tag pc[31:IDX_W+2], 32-bit target and 2-bit saturating counter.
REQ-013 SHALL look up the entry at index pc[IDX_W+1:2]; hit = valid & tag match; pred_taken = hit & counter[1]; pred_pc = pred_taken ? target : pc+4, with 32-bit wrap-around.
REQ-014 SHALL compute next_pc = redirect_valid ? redirect_pc : pred_pc; redirect SHALL always have priority over prediction.
REQ-015 SHALL set allow_in = ~if_valid | ipd_allow_in; ready_go SHALL be constant 1.
REQ-016 SHALL, when allow_in=1 or redirect_valid=1: load pc <= next_pc, set if_valid <= 1 and drive inst_ram_en=1 with inst_ram_addr=next_pc. The RAM is synchronous, so data is valid for pc in the following cycle.
REQ-017 SHALL, when allow_in=0 and redirect_valid=0: hold pc and if_valid and drive inst_ram_en=0 so the RAM output is held. inst_ram_addr SHALL still equal next_pc.
REQ-018 SHALL, on a redirect while stalled, discard the wrong-path IF content; the new pc replaces it and if_to_ipd_valid stays 1.
REQ-019 SHALL drive if_to_ipd_valid=if_valid, if_pc=pc, if_pred_pc=pred_pc and if_pred_taken=pred_taken, all combinational from current state.
REQ-020 SHALL drive inst_ram_w_en=4'b0 and inst_ram_w_data=32'b0 at all times.
REQ-021 SHALL, on upd_valid with a hit: increment the counter if upd_taken, saturating at 11, otherwise decrement it, saturating at 00; target <= upd_target when upd_taken.
REQ-022 SHALL, on upd_valid with a miss and upd_taken=1: allocate/overwrite the entry with valid=1, tag, target=upd_target and counter=10.
REQ-023 SHALL, on upd_valid with a miss and upd_taken=0, leave the table unchanged.
REQ-024 SHALL make a same-cycle lookup and update of the same entry use the pre-update contents; the update is visible from the next cycle.
REQ-025 SHALL apply updates independently of stall and redirect.

Reset
REQ-026 SHALL, while reset=1: set pc <= PC_RESET-4, set if_valid <= 0, clear all valid bits, set all counters <= 01 and drive inst_ram_en=0.
REQ-027 SHALL, in the first cycle after reset deasserts: drive inst_ram_en=1 and inst_ram_addr=PC_RESET, with pc <= PC_RESET and if_valid <= 1 at that edge.
REQ-028 SHALL, on reset asserted mid-stream, discard all in-flight state, any pending redirect and any pending update.

Verification
REQ-029 Reset release with ipd_allow_in=1 held and no updates -> inst_ram_addr 1c000000, 1c000004, 1c000008...; if_pc trails by one cycle; if_pred_taken=0.
REQ-030 Update pc=1c000010, taken, target=1c000100, then fetch reaches 1c000010 -> if_pred_taken=1, if_pred_pc=1c000100, next inst_ram_addr=1c000100.
REQ-031 Two not-taken updates on that entry (10->01->00) -> the next fetch of 1c000010 predicts 1c000014; a third not-taken update keeps the counter at 00.
REQ-032 ipd_allow_in=0 for 3 cycles at if_pc=1c000008 -> if_pc, if_to_ipd_valid and inst_ram_en=0 all held; resume fetches 1c00000c.
REQ-033 redirect_valid with redirect_pc=1c000200 during a stall and during a predicted-taken cycle -> next if_pc=1c000200 in both cases; the prediction is ignored.
REQ-034 Alias: BTB_ENTRIES=16, entry trained at 1c000010, lookup at 1c000050 (same index, different tag) -> miss, predict +4.
